// File: rtl/tlc_farm_sensor_conditioner_pkg.sv
// Shared definitions for the highway/farm traffic-light controller family:
// sensor-conditioner FSM states and the light encodings driven by the controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    REQUEST = 2'd2,
    SERVE   = 2'd3
  } tlc_state_e;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Decode a light bus into "this light is green"; used to derive farm_green.
  function automatic logic is_green(input logic [2:0] light);
    return light == GRN;
  endfunction

endpackage

// File: rtl/tlc_farm_sensor_conditioner_sync_debounce.sv
// Synchroniser chain plus counting debouncer for a raw asynchronous contact.
// filtered toggles only after DEBOUNCE_CYCLES consecutive mismatching samples;
// rise is a registered one-cycle pulse on each 0->1 change of filtered.
module tlc_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic filtered,
  output logic rise
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [DW-1:0]          deb_q, deb_d;
  logic                   filt_q, filt_d;
  logic                   rise_q, rise_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw input through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n)   sync_q <= '0;
    else if (ena) sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Count consecutive mismatches; any matching sample restarts the count.
  always_comb begin
    deb_d  = '0;
    filt_d = filt_q;
    rise_d = 1'b0;
    if (sync_out != filt_q) begin
      if (deb_q == DEB_LAST) begin
        filt_d = ~filt_q;
        rise_d = ~filt_q;
      end else begin
        deb_d = deb_q + DW'(1);
      end
    end
  end

  // Debounce state registers; frozen while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_q  <= '0;
      filt_q <= 1'b0;
      rise_q <= 1'b0;
    end else if (ena) begin
      deb_q  <= deb_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
    end
  end

  assign filtered = filt_q;
  assign rise     = rise_q;

endmodule

// File: rtl/tlc_farm_sensor_conditioner.sv
// Farm-road sensor conditioner: turns the raw vehicle loop into the clean
// level request C for the traffic-light controller, with a vehicle queue count.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no vehicle queued, waiting for a debounced arrival
//   ARMED   | vehicles queued below MIN_VEHICLES, wait timer running
//   REQUEST | req_out high, waiting for farm green as acknowledge
//   SERVE   | farm green in progress, queue cleared, arrivals not counted
module tlc_farm_sensor_conditioner
  import tlc_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 4,
  parameter int MIN_VEHICLES    = 1,
  parameter int MAX_WAIT        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             sensor_raw,
  input  logic             farm_green,
  output logic             req_out,
  output logic             vehicle_pulse,
  output logic [CNT_W-1:0] vehicle_count,
  output logic             overflow
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  MIN_V     = CNT_W'(MIN_VEHICLES);

  tlc_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               ovf_q, ovf_d;
  logic               req_q, req_d;
  logic               filtered, rise;

  tlc_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sync_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .din     (sensor_raw),
    .filtered(filtered),
    .rise    (rise)
  );

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // Next-state, queue count, wait timer and request decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    wait_d  = '0;
    if (rise && state_q != SERVE) begin
      cnt_d = cnt_inc;
      if (cnt_q == CNT_MAX) ovf_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (rise) state_d = (cnt_d >= MIN_V) ? REQUEST : ARMED;
      end
      ARMED: begin
        if (cnt_d >= MIN_V || wait_q == WAIT_LAST) state_d = REQUEST;
        else                                       wait_d  = wait_q + WAIT_W'(1);
      end
      REQUEST: begin
        // Queue clear on acknowledge beats a simultaneous arrival.
        if (farm_green) begin
          state_d = SERVE;
          cnt_d   = '0;
        end
      end
      SERVE: begin
        // A vehicle still on the loop at exit is re-queued as one.
        if (!farm_green) begin
          if (filtered) begin
            state_d = ARMED;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    req_d = (state_d == REQUEST);
  end

  // State and output registers; reset beats ena, ena low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wait_q  <= '0;
      ovf_q   <= 1'b0;
      req_q   <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      ovf_q   <= ovf_d;
      req_q   <= req_d;
    end
  end

  assign req_out       = req_q;
  assign vehicle_pulse = rise;
  assign vehicle_count = cnt_q;
  assign overflow      = ovf_q;

endmodule
